gesture_tracker: RTL

GESTURE_TRACKER -- requirements
Module: gesture_tracker

---
 rtl/gesture_pkg.sv | 48 ++++
 rtl/centroid_history.sv | 48 ++++
 rtl/gesture_tracker.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_pkg.sv
// Shared types, widths and the swipe classifier for the gesture tracker.
package gesture_pkg;

  localparam int unsigned X_W  = 11;
  localparam int unsigned Y_W  = 10;
  localparam int unsigned DX_W = X_W + 1;
  localparam int unsigned DY_W = Y_W + 1;
  localparam int unsigned S_W  = X_W + Y_W;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4
  } gesture_t;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    TRACK    = 2'd1,
    COOLDOWN = 2'd2
  } tracker_state_t;

  // Horizontal wins ties; a magnitude equal to its threshold is a detection.
  function automatic gesture_t classify(
    input logic signed [DX_W-1:0] dx,
    input logic signed [DY_W-1:0] dy,
    input logic        [DX_W-1:0] thx,
    input logic        [DX_W-1:0] thy
  );
    logic [DX_W-1:0] adx;
    logic [DY_W-1:0] ady_n;
    logic [DX_W-1:0] ady;
    gesture_t        g;
    adx   = dx[DX_W-1] ? DX_W'(-dx) : DX_W'(dx);
    ady_n = dy[DY_W-1] ? DY_W'(-dy) : DY_W'(dy);
    ady   = {1'b0, ady_n};
    if (adx >= thx && adx >= ady) begin
      g = (!dx[DX_W-1] && dx != '0) ? RIGHT : LEFT;
    end else if (ady >= thy) begin
      g = (!dy[DY_W-1] && dy != '0) ? DOWN : UP;
    end else begin
      g = NONE;
    end
    return g;
  endfunction

endpackage

// File: rtl/centroid_history.sv
// Circular buffer of packed {x, y} centroids. The entry at the write pointer
// is the oldest once the buffer has been filled, and is readable
// combinationally before the write of the same cycle replaces it.
module centroid_history
  import gesture_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 21
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   clr_cnt_i,
  output logic [W-1:0]           rd_oldest_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  assign rd_oldest_o = mem_q[wr_ptr_q];
  assign count_o     = cnt_q;

  // Storage, wrapping write pointer and saturating fill count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (clr_cnt_i) begin
        cnt_q <= '0;
      end else if (wr_en_i && cnt_q != CNT_W'(DEPTH)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gesture_tracker.sv
// Swipe detector: compares each centroid against the one HIST_DEPTH frames
// earlier and reports LEFT/RIGHT/UP/DOWN with a cooldown after each hit.
// Optional build macro SMOOTH_EN inserts an IIR smoother ahead of the history
// (adds one cycle of latency).
module gesture_tracker
  import gesture_pkg::*;
#(
  parameter int unsigned HIST_DEPTH      = 8,
  parameter int unsigned SWIPE_THRESH_X  = 200,
  parameter int unsigned SWIPE_THRESH_Y  = 150,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [X_W-1:0]         x_in,
  input  logic [Y_W-1:0]         y_in,
  input  logic                   valid_in,
  output logic [2:0]             gesture_out,
  output logic                   gesture_valid_out,
  output logic signed [DX_W-1:0] dx_out,
  output logic signed [DY_W-1:0] dy_out,
  output logic [1:0]             state_out
);

  localparam int unsigned CNT_W = $clog2(HIST_DEPTH) + 1;
  localparam int unsigned CD_W  = $clog2(COOLDOWN_FRAMES + 1);

  tracker_state_t state_q, state_d;
  logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;

  logic           smp_valid;
  logic [X_W-1:0] smp_x;
  logic [Y_W-1:0] smp_y;

  logic             hist_wr, hist_clr;
  logic [S_W-1:0]   hist_old;
  logic [CNT_W-1:0] hist_cnt;

  logic           s1_valid_q, s1_valid_d;
  logic [X_W-1:0] s1_xn_q, s1_xo_q;
  logic [Y_W-1:0] s1_yn_q, s1_yo_q;

  logic signed [DX_W-1:0] dx_c;
  logic signed [DY_W-1:0] dy_c;
  gesture_t               cls;
  logic                   det;

  gesture_t               gesture_q;
  logic                   gvalid_q;
  logic signed [DX_W-1:0] dx_q;
  logic signed [DY_W-1:0] dy_q;

`ifdef SMOOTH_EN
  logic           flt_valid_q, flt_valid_d;
  logic           flt_seeded_q, flt_seeded_d;
  logic [X_W-1:0] flt_x_q, flt_x_d;
  logic [Y_W-1:0] flt_y_q, flt_y_d;
  logic signed [X_W+1:0] fx_diff, fx_sum;
  logic signed [Y_W+1:0] fy_diff, fy_sum;
  logic           seed_clr;

  assign seed_clr = (state_q == COOLDOWN) && (state_d == FILL);

  // IIR step s += (in - s) >>> 2, reseeded by the first sample after a reseed point.
  always_comb begin
    flt_valid_d  = valid_in;
    flt_seeded_d = flt_seeded_q && !seed_clr;
    flt_x_d      = flt_x_q;
    flt_y_d      = flt_y_q;
    fx_diff      = $signed({2'b00, x_in}) - $signed({2'b00, flt_x_q});
    fy_diff      = $signed({2'b00, y_in}) - $signed({2'b00, flt_y_q});
    fx_sum       = $signed({2'b00, flt_x_q}) + (fx_diff >>> 2);
    fy_sum       = $signed({2'b00, flt_y_q}) + (fy_diff >>> 2);
    if (valid_in) begin
      if (flt_seeded_q && !seed_clr) begin
        flt_x_d = X_W'(fx_sum);
        flt_y_d = Y_W'(fy_sum);
      end else begin
        flt_x_d = x_in;
        flt_y_d = y_in;
      end
      flt_seeded_d = 1'b1;
    end
  end

  // Smoother registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      flt_valid_q  <= 1'b0;
      flt_seeded_q <= 1'b0;
      flt_x_q      <= '0;
      flt_y_q      <= '0;
    end else begin
      flt_valid_q  <= flt_valid_d;
      flt_seeded_q <= flt_seeded_d;
      flt_x_q      <= flt_x_d;
      flt_y_q      <= flt_y_d;
    end
  end

  // Filtered sample feeds the history.
  always_comb begin
    smp_valid = flt_valid_q;
    smp_x     = flt_x_q;
    smp_y     = flt_y_q;
  end
`else
  // Raw sample feeds the history.
  always_comb begin
    smp_valid = valid_in;
    smp_x     = x_in;
    smp_y     = y_in;
  end
`endif

  centroid_history #(
    .DEPTH(HIST_DEPTH),
    .W    (S_W)
  ) u_hist (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .wr_en_i    (hist_wr),
    .wr_data_i  ({smp_x, smp_y}),
    .clr_cnt_i  (hist_clr),
    .rd_oldest_o(hist_old),
    .count_o    (hist_cnt)
  );

  // Displacement and classification of the sample held in stage 1.
  always_comb begin
    dx_c = $signed({1'b0, s1_xn_q}) - $signed({1'b0, s1_xo_q});
    dy_c = $signed({1'b0, s1_yn_q}) - $signed({1'b0, s1_yo_q});
    cls  = classify(dx_c, dy_c, DX_W'(SWIPE_THRESH_X), DX_W'(SWIPE_THRESH_Y));
    det  = s1_valid_q && (cls != NONE);
  end

  // Next state, history control and stage-1 load.
  // A strobe arriving in the same cycle a detection resolves is already the
  // first cooldown frame, so the cooldown length is independent of strobe spacing.
  always_comb begin
    state_d    = state_q;
    cd_cnt_d   = cd_cnt_q;
    hist_wr    = 1'b0;
    hist_clr   = 1'b0;
    s1_valid_d = 1'b0;
    case (state_q)
      FILL: begin
        if (smp_valid) begin
          hist_wr = 1'b1;
          if (hist_cnt == CNT_W'(HIST_DEPTH - 1)) state_d = TRACK;
        end
      end
      TRACK: begin
        if (det) begin
          hist_clr = 1'b1;
          state_d  = COOLDOWN;
          cd_cnt_d = '0;
          if (smp_valid) begin
            if (COOLDOWN_FRAMES <= 1) state_d = FILL;
            else cd_cnt_d = CD_W'(1);
          end
        end else if (smp_valid) begin
          hist_wr    = 1'b1;
          s1_valid_d = 1'b1;
        end
      end
      COOLDOWN: begin
        if (smp_valid) begin
          if (cd_cnt_q == CD_W'(COOLDOWN_FRAMES - 1)) begin
            state_d  = FILL;
            cd_cnt_d = '0;
          end else begin
            cd_cnt_d = cd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // FSM state and cooldown counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= FILL;
      cd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cd_cnt_q <= cd_cnt_d;
    end
  end

  // Stage 1: capture new sample alongside the oldest entry it replaces.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_xn_q    <= '0;
      s1_yn_q    <= '0;
      s1_xo_q    <= '0;
      s1_yo_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_valid_d) begin
        s1_xn_q <= smp_x;
        s1_yn_q <= smp_y;
        s1_xo_q <= hist_old[S_W-1:Y_W];
        s1_yo_q <= hist_old[Y_W-1:0];
      end
    end
  end

  // Stage 2: result registers; gesture only latches on a real detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gesture_q <= NONE;
      gvalid_q  <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
    end else begin
      gvalid_q <= det;
      if (s1_valid_q) begin
        dx_q <= dx_c;
        dy_q <= dy_c;
        if (det) gesture_q <= cls;
      end
    end
  end

  assign gesture_out       = gesture_q;
  assign gesture_valid_out = gvalid_q;
  assign dx_out            = dx_q;
  assign dy_out            = dy_q;
  assign state_out         = state_q;

endmodule
